rf_write_master: RTL and testbench
==================================

RF_WRITE_MASTER -- requirements
Module: rf_write_master

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the register data width; 32 serves the scalar file and 128 the vector file.
REQ-002 SHALL have parameter DEPTH, default 4, the pending-write queue depth; it shall be a power of two and at least 2.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port req_valid  input  1  producer offers a write request.
REQ-006 SHALL have port req_ready  output  1  the block accepts the request this cycle.
REQ-007 SHALL have port req_addr  input  4  destination register index, 0-15.
REQ-008 SHALL have port req_data  input  WIDTH  write data.
REQ-009 SHALL have port rf_stall  input  1  the regfile write port is taken by a higher-priority writer this cycle.
REQ-010 SHALL have ports rf_we (1), rf_wr_addr (4) and rf_wr_data (WIDTH), all outputs, driving the regfile write port (we, wr_addr, wr_data).
REQ-011 SHALL have port busy  output  16  bit i is set while any queued entry targets register i.
REQ-012 SHALL have port count  output  $clog2(DEPTH)+1  number of queued entries.
REQ-013 SHALL have ports lk_addr1/lk_addr2 (4, input), lk_hit1/lk_hit2 (1, output) and lk_data1/lk_data2 (WIDTH, output), the lookup ports for the regfile read addresses.

Function
REQ-014 SHALL hold queued requests in a FIFO of DEPTH entries, each entry being {addr, data}.
REQ-015 SHALL drive req_ready = (count < DEPTH), combinationally from registered state only.
REQ-016 SHALL push an entry at the edge where req_valid && req_ready.
REQ-017 SHALL drive rf_we = (count != 0) && !rf_stall, with rf_wr_addr/rf_wr_data equal to the head entry; the head pops at the same edge that rf_we is high.
REQ-018 SHALL give latency of exactly one cycle from acceptance to rf_we when the queue is empty and rf_stall is low.
REQ-019 SHALL, on a simultaneous push and pop, keep count unchanged and keep order intact; when full, no push occurs even if a pop occurs in that cycle.
REQ-020 SHALL drive rf_wr_addr and rf_wr_data to 0 whenever rf_we is low.
REQ-021 SHALL wrap its pointers modulo DEPTH; count shall never exceed DEPTH or underflow.
REQ-022 SHALL keep multiple queued writes to the same address and issue all of them in order, with no coalescing.
REQ-023 SHALL derive busy combinationally from valid entries.

Reset
REQ-024 SHALL, while rst is high, clear the pointers and count; outputs are then req_ready=1, rf_we=0, rf_wr_addr=0, rf_wr_data=0, busy=0, lk_hit*=0 and lk_data*=0.
REQ-025 SHALL, on reset asserted mid-operation, discard all queued entries immediately; no regfile write issues for them.

Configuration
REQ-026 SHALL, with RF_WR_BYPASS_EN defined, set lk_hitN=1 when any queued entry matches lk_addrN, and set lk_dataN to the data of the youngest matching entry.
REQ-027 SHALL, without RF_WR_BYPASS_EN, tie lk_hit* and lk_data* to 0; ports remain present in both builds.

Structure
REQ-028 SHALL take from shared package geva_rf_pkg: RF_ADDR_W=4, RF_NUM_REGS=16 and the parameterized request struct typedef rf_wr_req_t {addr, data}.
REQ-029 SHALL place the queue in sub-module rf_wr_fifo (storage, pointers, count); busy, lookup and port drive stay in rf_write_master.

Verification
REQ-030 SHALL verify single write: push addr 3 data 78 (WIDTH=32), rf_stall=0 -> next cycle rf_we=1, rf_wr_addr=3, rf_wr_data=78; busy[3]=1 for one cycle, then 0.
REQ-031 SHALL verify fill under stall: rf_stall=1, push addr 1,2,3,4 -> count=4, req_ready=0, a fifth push is refused; release the stall -> writes issue in order 1,2,3,4 on consecutive cycles.
REQ-032 SHALL verify simultaneous push and pop at count=2 -> count stays 2 and issue order is preserved.
REQ-033 SHALL verify bypass (RF_WR_BYPASS_EN, WIDTH=128): stall, push addr 4 data 455 then addr 4 data 788, lk_addr1=4 -> lk_hit1=1 and lk_data1=788; without the macro -> lk_hit1=0.
REQ-034 SHALL verify reset mid-operation: assert rst with 3 entries queued -> count=0, busy=0, rf_we=0 immediately, with no write issued afterward.

Source files
------------

// File: rtl/geva_rf_pkg.sv
// Shared regfile definitions: register index width, register count and the
// write-request bundle carried from producers into the regfile write path.
package geva_rf_pkg;

   localparam int RF_ADDR_W     = 4;
   localparam int RF_NUM_REGS   = 16;
   // Widest regfile data path (vector file). Narrower instances zero-extend
   // into this field and use only the low WIDTH bits; the constant upper bits
   // are pruned by synthesis.
   localparam int RF_DATA_MAX_W = 128;

   typedef struct packed {
      logic [RF_ADDR_W-1:0]     addr;
      logic [RF_DATA_MAX_W-1:0] data;
   } rf_wr_req_t;

   // Build a request from a register index and write data of up to RF_DATA_MAX_W bits.
   function automatic rf_wr_req_t rf_wr_req_make(input logic [RF_ADDR_W-1:0]     addr,
                                                 input logic [RF_DATA_MAX_W-1:0] data);
      rf_wr_req_t r;
      r.addr = addr;
      r.data = data;
      return r;
   endfunction

endpackage

// File: rtl/rf_wr_fifo.sv
// Pending-write queue: DEPTH entries of {addr, data}, wrap-around pointers and
// an occupancy count. All entries are exposed in parallel so the parent can
// derive busy flags and lookups; rd_ptr marks the oldest entry.
module rf_wr_fifo
   import geva_rf_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  rf_wr_req_t             push_entry,
   input  logic                   pop,
   output rf_wr_req_t             head_entry,
   output rf_wr_req_t             entries [DEPTH],
   output logic [$clog2(DEPTH)-1:0] rd_ptr,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;
   logic             push_ok;
   logic             pop_ok;

   // Guard against overflow/underflow even if the parent mis-drives push/pop.
   assign push_ok = push && (count_q != CNT_W'(DEPTH));
   assign pop_ok  = pop  && (count_q != '0);

   // Next pointers and count; power-of-two DEPTH makes wrap a natural overflow.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers; reset empties the queue at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         rf_wr_req_t entry_q;
         rf_wr_req_t entry_d;

         // Capture the incoming request when this slot is the write target.
         always_comb begin
            entry_d = entry_q;
            if (push_ok && (wr_ptr_q == PTR_W'(gi))) begin
               entry_d = push_entry;
            end
         end

         // Storage needs no reset: validity comes solely from rd_ptr and count.
         always_ff @(posedge clk) begin
            entry_q <= entry_d;
         end

         assign entries[gi] = entry_q;
      end
   endgenerate

   assign head_entry = entries[rd_ptr_q];
   assign rd_ptr     = rd_ptr_q;
   assign count      = count_q;

endmodule

// File: rtl/rf_write_master.sv
// Regfile write master: queues write requests and drains them into the
// regfile write port whenever the port is not taken by a higher-priority
// writer. Publishes per-register busy flags and, when RF_WR_BYPASS_EN is
// defined, forwards the youngest queued data for two read addresses.
// Optional feature macro: RF_WR_BYPASS_EN. WIDTH must not exceed RF_DATA_MAX_W;
// DEPTH must be a power of two, at least 2.
module rf_write_master
   import geva_rf_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [RF_ADDR_W-1:0]     req_addr,
   input  logic [WIDTH-1:0]         req_data,
   input  logic                     rf_stall,
   output logic                     rf_we,
   output logic [RF_ADDR_W-1:0]     rf_wr_addr,
   output logic [WIDTH-1:0]         rf_wr_data,
   output logic [RF_NUM_REGS-1:0]   busy,
   output logic [$clog2(DEPTH):0]   count,
   input  logic [RF_ADDR_W-1:0]     lk_addr1,
   input  logic [RF_ADDR_W-1:0]     lk_addr2,
   output logic                     lk_hit1,
   output logic                     lk_hit2,
   output logic [WIDTH-1:0]         lk_data1,
   output logic [WIDTH-1:0]         lk_data2
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   rf_wr_req_t       entries [DEPTH];
   rf_wr_req_t       head_entry;
   rf_wr_req_t       push_entry;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] fifo_count;
   logic             push;
   logic             pop;

   // Ready depends only on the registered count, never on req_valid.
   assign req_ready  = (fifo_count < CNT_W'(DEPTH));
   assign push       = req_valid && req_ready;
   assign pop        = (fifo_count != '0) && !rf_stall;
   assign push_entry = rf_wr_req_make(req_addr, RF_DATA_MAX_W'(req_data));
   assign count      = fifo_count;

   rf_wr_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .head_entry (head_entry),
      .entries    (entries),
      .rd_ptr     (rd_ptr),
      .count      (fifo_count)
   );

   // Drive the regfile write port from the head; idle port shows all zeros.
   always_comb begin
      rf_we      = pop;
      rf_wr_addr = '0;
      rf_wr_data = '0;
      if (pop) begin
         rf_wr_addr = head_entry.addr;
         rf_wr_data = head_entry.data[WIDTH-1:0];
      end
   end

   // Flag every register targeted by at least one valid queued entry.
   always_comb begin
      busy = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (CNT_W'(k) < fifo_count) begin
            busy[entries[rd_ptr + PTR_W'(k)].addr] = 1'b1;
         end
      end
   end

   logic [RF_ADDR_W-1:0] lk_addr_arr [2];
   assign lk_addr_arr[0] = lk_addr1;
   assign lk_addr_arr[1] = lk_addr2;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_lk
         logic             hit;
         logic [WIDTH-1:0] data;
`ifdef RF_WR_BYPASS_EN
         // Scan oldest to youngest so the youngest matching entry wins.
         always_comb begin
            hit  = 1'b0;
            data = '0;
            for (int k = 0; k < DEPTH; k++) begin
               if ((CNT_W'(k) < fifo_count) &&
                   (entries[rd_ptr + PTR_W'(k)].addr == lk_addr_arr[gi])) begin
                  hit  = 1'b1;
                  data = entries[rd_ptr + PTR_W'(k)].data[WIDTH-1:0];
               end
            end
         end
`else
         // Forwarding disabled: lookup ports stay present but inert.
         always_comb begin
            hit  = 1'b0;
            data = '0;
         end
`endif
      end
   endgenerate

   assign lk_hit1  = g_lk[0].hit;
   assign lk_data1 = g_lk[0].data;
   assign lk_hit2  = g_lk[1].hit;
   assign lk_data2 = g_lk[1].data;

endmodule

// File: tb/tb_rf_write_master.sv
// Testbench for rf_write_master: directed scenarios followed by random
// traffic, every cycle compared against a queue-based reference model.
module tb_rf_write_master;

`ifdef RF_WR_BYPASS_EN
   localparam int W = 128;
   localparam bit BYP = 1'b1;
`else
   localparam int W = 32;
   localparam bit BYP = 1'b0;
`endif
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic [3:0]    req_addr;
   logic [W-1:0]  req_data;
   logic          rf_stall;
   logic          rf_we;
   logic [3:0]    rf_wr_addr;
   logic [W-1:0]  rf_wr_data;
   logic [15:0]   busy;
   logic [2:0]    count;
   logic [3:0]    lk_addr1, lk_addr2;
   logic          lk_hit1, lk_hit2;
   logic [W-1:0]  lk_data1, lk_data2;

   rf_write_master #(.WIDTH(W), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_data   (req_data),
      .rf_stall   (rf_stall),
      .rf_we      (rf_we),
      .rf_wr_addr (rf_wr_addr),
      .rf_wr_data (rf_wr_data),
      .busy       (busy),
      .count      (count),
      .lk_addr1   (lk_addr1),
      .lk_addr2   (lk_addr2),
      .lk_hit1    (lk_hit1),
      .lk_hit2    (lk_hit2),
      .lk_data1   (lk_data1),
      .lk_data2   (lk_data2)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]   a;
      logic [W-1:0] d;
   } ent_t;

   ent_t model[$];
   int   checks = 0;
   int   errors = 0;

   // Values seen in the most recent step, before its clock edge.
   logic          obs_we, obs_ready;
   logic [3:0]    obs_addr;
   logic [W-1:0]  obs_data;
   logic [15:0]   obs_busy;
   logic [2:0]    obs_count;
   logic          obs_hit1;
   logic [W-1:0]  obs_lkd1;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Youngest queued entry for addr, if any.
   task automatic model_lookup(input logic [3:0] addr, output logic hit, output logic [W-1:0] data);
      hit  = 1'b0;
      data = '0;
      foreach (model[i]) begin
         if (model[i].a == addr) begin
            hit  = 1'b1;
            data = model[i].d;
         end
      end
      if (!BYP) begin
         hit  = 1'b0;
         data = '0;
      end
   endtask

   task automatic compare_all();
      int           n;
      logic         e_we;
      logic [3:0]   e_addr;
      logic [W-1:0] e_data;
      logic [15:0]  e_busy;
      logic         e_h1, e_h2;
      logic [W-1:0] e_d1, e_d2;
      n      = model.size();
      e_we   = (n != 0) && !rf_stall;
      e_addr = e_we ? model[0].a : 4'd0;
      e_data = e_we ? model[0].d : '0;
      e_busy = '0;
      foreach (model[i]) e_busy[model[i].a] = 1'b1;
      model_lookup(lk_addr1, e_h1, e_d1);
      model_lookup(lk_addr2, e_h2, e_d2);
      check("req_ready", req_ready, (n < DEPTH));
      check("rf_we", rf_we, e_we);
      check("rf_wr_addr", rf_wr_addr, e_addr);
      check("rf_wr_data", rf_wr_data, e_data);
      check("count", count, n);
      check("busy", busy, e_busy);
      check("lk_hit1", lk_hit1, e_h1);
      check("lk_data1", lk_data1, e_d1);
      check("lk_hit2", lk_hit2, e_h2);
      check("lk_data2", lk_data2, e_d2);
      obs_we = rf_we; obs_ready = req_ready; obs_addr = rf_wr_addr; obs_data = rf_wr_data;
      obs_busy = busy; obs_count = count; obs_hit1 = lk_hit1; obs_lkd1 = lk_data1;
   endtask

   // One clock: apply inputs after the falling edge, compare, advance model at the rising edge.
   task automatic step(input logic v, input logic [3:0] a, input logic [W-1:0] d,
                       input logic s, input logic [3:0] l1, input logic [3:0] l2);
      bit do_push, do_pop;
      ent_t e;
      req_valid = v; req_addr = a; req_data = d; rf_stall = s;
      lk_addr1 = l1; lk_addr2 = l2;
      #1;
      compare_all();
      do_push = v && (model.size() < DEPTH);
      do_pop  = (model.size() != 0) && !s;
      @(posedge clk);
      if (do_pop) begin
         $display("issue addr %0d data %0h", model[0].a, model[0].d);
         void'(model.pop_front());
      end
      if (do_push) begin
         e.a = a; e.d = d;
         model.push_back(e);
      end
      @(negedge clk);
   endtask

   function automatic logic [W-1:0] rnd_data();
      logic [127:0] r;
      r = {$urandom, $urandom, $urandom, $urandom};
      return r[W-1:0];
   endfunction

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; rf_stall = 1'b0;
      lk_addr1 = '0; lk_addr2 = '0;
      #1;
      check("rst_ready", req_ready, 1'b1);
      check("rst_we", rf_we, 1'b0);
      check("rst_addr", rf_wr_addr, 4'd0);
      check("rst_data", rf_wr_data, '0);
      check("rst_busy", busy, 16'd0);
      check("rst_count", count, 3'd0);
      check("rst_hit", {lk_hit1, lk_hit2}, 2'b00);
      check("rst_lkdata", {lk_data1, lk_data2}, '0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Single write with one-cycle latency.
      step(1'b1, 4'd3, W'(78), 1'b0, 4'd0, 4'd0);
      check("single_we_before", obs_we, 1'b0);
      step(1'b0, 4'd0, '0, 1'b0, 4'd3, 4'd0);
      check("single_we", obs_we, 1'b1);
      check("single_addr", obs_addr, 4'd3);
      check("single_data", obs_data, W'(78));
      check("single_busy3", obs_busy[3], 1'b1);
      step(1'b0, 4'd0, '0, 1'b0, 4'd0, 4'd0);
      check("single_busy3_clear", obs_busy[3], 1'b0);
      check("single_we_after", obs_we, 1'b0);
      $display("single write done");

      // Fill under stall, refused fifth push, ordered drain.
      for (int i = 1; i <= 4; i++) step(1'b1, 4'(i), rnd_data(), 1'b1, 4'd0, 4'd0);
      step(1'b1, 4'd5, rnd_data(), 1'b1, 4'd0, 4'd0);
      check("fill_count", obs_count, 3'd4);
      check("fill_ready", obs_ready, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         step(1'b0, 4'd0, '0, 1'b0, 4'd0, 4'd0);
         check("drain_we", obs_we, 1'b1);
         check("drain_addr", obs_addr, 4'(i));
      end
      step(1'b0, 4'd0, '0, 1'b0, 4'd0, 4'd0);
      check("drain_no_fifth", obs_we, 1'b0);
      $display("fill under stall done");

      // Simultaneous push and pop at count 2.
      step(1'b1, 4'd6, rnd_data(), 1'b1, 4'd0, 4'd0);
      step(1'b1, 4'd7, rnd_data(), 1'b1, 4'd0, 4'd0);
      step(1'b1, 4'd8, rnd_data(), 1'b0, 4'd0, 4'd0);
      check("pushpop_addr", obs_addr, 4'd6);
      step(1'b0, 4'd0, '0, 1'b1, 4'd0, 4'd0);
      check("pushpop_count", obs_count, 3'd2);
      step(1'b0, 4'd0, '0, 1'b0, 4'd0, 4'd0);
      check("pushpop_order1", obs_addr, 4'd7);
      step(1'b0, 4'd0, '0, 1'b0, 4'd0, 4'd0);
      check("pushpop_order2", obs_addr, 4'd8);
      $display("push and pop done");

      // Same-address writes: lookup returns the youngest.
      step(1'b1, 4'd4, W'(455), 1'b1, 4'd0, 4'd0);
      step(1'b1, 4'd4, W'(788), 1'b1, 4'd0, 4'd0);
      step(1'b0, 4'd0, '0, 1'b1, 4'd4, 4'd9);
      check("bypass_hit1", obs_hit1, BYP);
      check("bypass_data1", obs_lkd1, BYP ? W'(788) : '0);
      step(1'b0, 4'd0, '0, 1'b0, 4'd4, 4'd4);
      check("dup_first", obs_data, W'(455));
      step(1'b0, 4'd0, '0, 1'b0, 4'd4, 4'd4);
      check("dup_second", obs_data, W'(788));
      $display("same address done");

      // Reset mid-operation with three entries queued.
      for (int i = 0; i < 3; i++) step(1'b1, 4'(10 + i), rnd_data(), 1'b1, 4'd0, 4'd0);
      rf_stall = 1'b0; req_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("midrst_count", count, 3'd0);
      check("midrst_busy", busy, 16'd0);
      check("midrst_we", rf_we, 1'b0);
      check("midrst_ready", req_ready, 1'b1);
      model.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 4'd0, '0, 1'b0, 4'd10, 4'd11);
         check("postrst_we", obs_we, 1'b0);
      end
      $display("mid reset done");

      // Random traffic; narrow address range at times to force duplicates.
      for (int c = 0; c < 400; c++) begin
         logic [3:0] a;
         a = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
         step($urandom_range(0, 9) < 7, a, rnd_data(), $urandom_range(0, 9) < 3,
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
